// File: rtl/pma_pkg.sv
// Shared types, default region map and the range-hit helper for the PMA lookup.
package pma_pkg;

  localparam int unsigned MAX_RULES = 16;

  typedef enum logic [1:0] {
    PMA_FETCH = 2'd0,
    PMA_LOAD  = 2'd1,
    PMA_STORE = 2'd2,
    PMA_AMO   = 2'd3
  } pma_access_e;

  typedef struct packed {
    logic exec;
    logic cached;
    logic nonidem;
  } pma_attr_t;

  typedef struct packed {
    logic [31:0]                    NrNonIdempotentRules;
    logic [MAX_RULES-1:0][63:0]     NonIdempotentAddrBase;
    logic [MAX_RULES-1:0][63:0]     NonIdempotentLength;
    logic [31:0]                    NrExecuteRegionRules;
    logic [MAX_RULES-1:0][63:0]     ExecuteRegionAddrBase;
    logic [MAX_RULES-1:0][63:0]     ExecuteRegionLength;
    logic [31:0]                    NrCachedRegionRules;
    logic [MAX_RULES-1:0][63:0]     CachedRegionAddrBase;
    logic [MAX_RULES-1:0][63:0]     CachedRegionLength;
    logic                           NonIdemPotenceEn;
  } pma_cfg_t;

  // Default map: debug (0x0/4K), boot ROM (0x1_0000/64K), DRAM (0x8000_0000/1G, also cached).
  localparam pma_cfg_t cva6_cfg = '{
    NrNonIdempotentRules:  32'd2,
    NonIdempotentAddrBase: '0,
    NonIdempotentLength:   '0,
    NrExecuteRegionRules:  32'd3,
    ExecuteRegionAddrBase: {{13{64'h0}}, 64'h8000_0000, 64'h1_0000, 64'h0},
    ExecuteRegionLength:   {{13{64'h0}}, 64'h4000_0000, 64'h1_0000, 64'h1000},
    NrCachedRegionRules:   32'd1,
    CachedRegionAddrBase:  {{15{64'h0}}, 64'h8000_0000},
    CachedRegionLength:    {{15{64'h0}}, 64'h4000_0000},
    NonIdemPotenceEn:      1'b0
  };

  // Operands are truncated to plen bits and summed one bit wider, so regions ending at the top never wrap.
  function automatic logic range_hit(input logic [63:0] addr, input logic [63:0] base,
                                     input logic [63:0] len, input int unsigned plen);
    logic [64:0] mask;
    logic [64:0] a;
    logic [64:0] b;
    logic [64:0] l;
    mask = (65'd1 << plen) - 65'd1;
    a    = {1'b0, addr} & mask;
    b    = {1'b0, base} & mask;
    l    = {1'b0, len} & mask;
    return (l != 65'd0) && (a >= b) && (a < (b + l));
  endfunction

endpackage

// File: rtl/pma_rule_match.sv
// Evaluates one region table against an address; hit is the OR over the first i_nr slots.
module pma_rule_match
  import pma_pkg::*;
#(
  parameter int unsigned PLEN     = 56,
  parameter int unsigned MaxRules = 16
) (
  input  logic [31:0]               i_nr,
  input  logic [MaxRules-1:0][63:0] i_base,
  input  logic [MaxRules-1:0][63:0] i_len,
  input  logic [PLEN-1:0]           i_addr,
  output logic                      o_hit
);

  logic [63:0] w_addr;

  assign w_addr = 64'(i_addr);

  always_comb begin
    o_hit = 1'b0;
    for (int unsigned i = 0; i < MaxRules; i++) begin
      if ((i < i_nr) && range_hit(w_addr, i_base[i], i_len[i], PLEN)) begin
        o_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pma_region_checker.sv
// One-stage PMA lookup (exec/cached/nonidem + access fault) with valid/ready, one result per cycle.
// Define CVA6_PMA_FAULT_CNT_EN to add a saturating fault counter on fault_cnt_o.
module pma_region_checker
  import pma_pkg::*;
#(
  parameter pma_cfg_t    CVA6Cfg  = cva6_cfg,
  parameter int unsigned PLEN     = 56,
  parameter int unsigned MaxRules = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
`ifdef CVA6_PMA_FAULT_CNT_EN
  output logic [31:0]     fault_cnt_o,
`endif
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [PLEN-1:0] req_paddr_i,
  input  logic [1:0]      req_type_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [PLEN-1:0] resp_paddr_o,
  output logic            resp_exec_o,
  output logic            resp_cached_o,
  output logic            resp_nonidem_o,
  output logic            resp_fault_o
);

  if ((MaxRules > MAX_RULES) || (CVA6Cfg.NrExecuteRegionRules > MaxRules) ||
      (CVA6Cfg.NrCachedRegionRules > MaxRules) || (CVA6Cfg.NrNonIdempotentRules > MaxRules)) begin : g_cfg_err
    $error("pma_region_checker: rule count exceeds MaxRules");
  end

  logic            w_exec_hit;
  logic            w_cached_hit;
  logic            w_nonidem_hit;
  pma_attr_t       w_attr;
  pma_access_e     w_type;
  logic            w_fault;
  logic            w_accept;

  logic            r_resp_valid;
  logic [PLEN-1:0] r_resp_paddr;
  pma_attr_t       r_resp_attr;
  logic            r_resp_fault;

  pma_rule_match #(.PLEN(PLEN), .MaxRules(MaxRules)) u_exec (
    .i_nr   (CVA6Cfg.NrExecuteRegionRules),
    .i_base (CVA6Cfg.ExecuteRegionAddrBase[MaxRules-1:0]),
    .i_len  (CVA6Cfg.ExecuteRegionLength[MaxRules-1:0]),
    .i_addr (req_paddr_i),
    .o_hit  (w_exec_hit)
  );

  pma_rule_match #(.PLEN(PLEN), .MaxRules(MaxRules)) u_cached (
    .i_nr   (CVA6Cfg.NrCachedRegionRules),
    .i_base (CVA6Cfg.CachedRegionAddrBase[MaxRules-1:0]),
    .i_len  (CVA6Cfg.CachedRegionLength[MaxRules-1:0]),
    .i_addr (req_paddr_i),
    .o_hit  (w_cached_hit)
  );

  pma_rule_match #(.PLEN(PLEN), .MaxRules(MaxRules)) u_nonidem (
    .i_nr   (CVA6Cfg.NrNonIdempotentRules),
    .i_base (CVA6Cfg.NonIdempotentAddrBase[MaxRules-1:0]),
    .i_len  (CVA6Cfg.NonIdempotentLength[MaxRules-1:0]),
    .i_addr (req_paddr_i),
    .o_hit  (w_nonidem_hit)
  );

  assign w_type = pma_access_e'(req_type_i);

  always_comb begin
    w_attr         = '0;
    w_attr.exec    = w_exec_hit;
    w_attr.cached  = w_cached_hit;
    w_attr.nonidem = CVA6Cfg.NonIdemPotenceEn & w_nonidem_hit;
    w_fault        = ((w_type == PMA_FETCH) && !w_attr.exec) ||
                     ((w_type == PMA_AMO)   && !w_attr.cached);
  end

  // resp_ready_i reaches req_ready_o combinationally; resp data only ever comes from registers.
  assign req_ready_o = !r_resp_valid || resp_ready_i;
  assign w_accept    = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_resp_valid <= 1'b0;
      r_resp_paddr <= '0;
      r_resp_attr  <= '0;
      r_resp_fault <= 1'b0;
    end else if (w_accept) begin
      r_resp_valid <= 1'b1;
      r_resp_paddr <= req_paddr_i;
      r_resp_attr  <= w_attr;
      r_resp_fault <= w_fault;
    end else if (resp_ready_i) begin
      r_resp_valid <= 1'b0;
    end
  end

  assign resp_valid_o   = r_resp_valid;
  assign resp_paddr_o   = r_resp_paddr;
  assign resp_exec_o    = r_resp_attr.exec;
  assign resp_cached_o  = r_resp_attr.cached;
  assign resp_nonidem_o = r_resp_attr.nonidem;
  assign resp_fault_o   = r_resp_fault;

`ifdef CVA6_PMA_FAULT_CNT_EN
  logic [31:0] r_fault_cnt;
  logic        w_fault_hs;

  assign w_fault_hs = r_resp_valid && resp_ready_i && r_resp_fault;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fault_cnt <= '0;
    end else if (w_fault_hs && (r_fault_cnt != 32'hFFFF_FFFF)) begin
      r_fault_cnt <= r_fault_cnt + 32'd1;
    end
  end

  assign fault_cnt_o = r_fault_cnt;
`endif

endmodule

// File: tb/tb_pma_region_checker.sv
// Randomized scoreboard bench for pma_region_checker against a region-list reference model.
module tb_pma_region_checker;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [55:0] req_paddr_i;
  logic [1:0]  req_type_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [55:0] resp_paddr_o;
  logic        resp_exec_o;
  logic        resp_cached_o;
  logic        resp_nonidem_o;
  logic        resp_fault_o;
`ifdef CVA6_PMA_FAULT_CNT_EN
  logic [31:0] fault_cnt_o;
`endif

  pma_region_checker dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
`ifdef CVA6_PMA_FAULT_CNT_EN
    .fault_cnt_o    (fault_cnt_o),
`endif
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_paddr_i    (req_paddr_i),
    .req_type_i     (req_type_i),
    .resp_valid_o   (resp_valid_o),
    .resp_ready_i   (resp_ready_i),
    .resp_paddr_o   (resp_paddr_o),
    .resp_exec_o    (resp_exec_o),
    .resp_cached_o  (resp_cached_o),
    .resp_nonidem_o (resp_nonidem_o),
    .resp_fault_o   (resp_fault_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [55:0] addr;
    logic        exec;
    logic        cached;
    logic        nonidem;
    logic        fault;
    int          stamp;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  bit          bp_rand = 1'b0;
  logic [31:0] exp_cnt = '0;

  always @(posedge clk_i) cyc++;

  // Default memory map: execute = debug, boot ROM, DRAM; cached = DRAM; nothing non-idempotent.
  longint unsigned ex_base[3] = '{64'h0, 64'h1_0000, 64'h8000_0000};
  longint unsigned ex_len[3]  = '{64'h1000, 64'h1_0000, 64'h4000_0000};
  longint unsigned ca_base    = 64'h8000_0000;
  longint unsigned ca_len     = 64'h4000_0000;

  function automatic bit in_rgn(longint unsigned a, longint unsigned b, longint unsigned l);
    return (l != 0) && (a >= b) && (a < b + l);
  endfunction

  function automatic exp_t model(logic [55:0] a, logic [1:0] t);
    exp_t e;
    longint unsigned x;
    x = {8'h0, a};
    e.addr = a;
    e.exec = 1'b0;
    for (int i = 0; i < 3; i++) if (in_rgn(x, ex_base[i], ex_len[i])) e.exec = 1'b1;
    e.cached  = in_rgn(x, ca_base, ca_len);
    e.nonidem = 1'b0;
    e.fault   = ((t == 2'd0) && !e.exec) || ((t == 2'd3) && !e.cached);
    e.stamp   = 0;
    return e;
  endfunction

  task automatic chk_b(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, req, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs sampled at negedge; a handshake seen here completes at the next posedge.
  always @(negedge clk_i) begin
    if (!rst_i) begin
`ifdef CVA6_PMA_FAULT_CNT_EN
      chk_w("fault_cnt", 64'(fault_cnt_o), 64'(exp_cnt));
`endif
      if ((q.size() > 0) && (q[0].stamp + 1 == cyc)) chk_b("latency_valid", resp_valid_o, 1'b1);
      if (resp_valid_o) begin
        if (q.size() == 0) begin
          chk_b("spurious_valid", resp_valid_o, 1'b0);
        end else begin
          chk_w("paddr", 64'(resp_paddr_o), 64'(q[0].addr));
          chk_b("exec", resp_exec_o, q[0].exec);
          chk_b("cached", resp_cached_o, q[0].cached);
          chk_b("nonidem", resp_nonidem_o, q[0].nonidem);
          chk_b("fault", resp_fault_o, q[0].fault);
          if (resp_ready_i) begin
            if (q[0].fault && (exp_cnt != 32'hFFFF_FFFF)) exp_cnt = exp_cnt + 32'd1;
            void'(q.pop_front());
          end
        end
      end
    end
  end

  always @(posedge clk_i) begin
    if (bp_rand) begin
      #1;
      resp_ready_i = (($urandom % 4) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the cycle in which the request was accepted.
  task automatic send(input logic [55:0] a, input logic [1:0] t);
    exp_t e;
    int   n;
    bit   done;
    n    = 0;
    done = 1'b0;
    req_valid_i = 1'b1;
    req_paddr_i = a;
    req_type_i  = t;
    while (!done) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        e = model(a, t);
        e.stamp = cyc;
        q.push_back(e);
        done = 1'b1;
      end else if (++n > 200) begin
        total++;
        bad++;
        $display("FAIL send_timeout actual=no_accept required=accept addr=0x%0h", a);
        done = 1'b1;
      end
      @(posedge clk_i);
      #1;
    end
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() > 0) && (n < 100)) begin
      @(posedge clk_i);
      n++;
    end
    #1;
    chk_w("drain_queue_empty", 64'(q.size()), 64'd0);
  endtask

  function automatic logic [55:0] rand_addr();
    longint unsigned pts[6] = '{64'h0, 64'h1000, 64'h1_0000, 64'h2_0000, 64'h8000_0000, 64'hC000_0000};
    longint unsigned v;
    case ($urandom % 4)
      0, 1: v = pts[$urandom % 6] + 64'($urandom % 3) - 64'd1;
      2:    v = 64'($urandom % 32'h0002_2000);
      default: v = {8'h0, 24'($urandom), $urandom};
    endcase
    return v[55:0];
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i        = 1'b1;
    req_valid_i  = 1'b0;
    req_paddr_i  = '0;
    req_type_i   = 2'd0;
    resp_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk_b("rst_valid", resp_valid_o, 1'b0);
    chk_w("rst_paddr", 64'(resp_paddr_o), 64'd0);
    chk_b("rst_exec", resp_exec_o, 1'b0);
    chk_b("rst_cached", resp_cached_o, 1'b0);
    chk_b("rst_fault", resp_fault_o, 1'b0);
`ifdef CVA6_PMA_FAULT_CNT_EN
    chk_w("rst_cnt", 64'(fault_cnt_o), 64'd0);
`endif
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk_b("post_rst_ready", req_ready_o, 1'b1);
    @(posedge clk_i);
    #1;

    // Directed points and region boundaries
    send(56'h8000_1000, 2'd0);
    send(56'h1_0000,    2'd0);
    send(56'h1_0000,    2'd3);
    send(56'hBFFF_FFFF, 2'd0);
    send(56'hC000_0000, 2'd0);
    send(56'h2000_0000, 2'd1);
    send(56'hFF_FFFF_FFFF_FFFF, 2'd2);
    drain();

    // Backpressure: A is held while B waits for three cycles
    resp_ready_i = 1'b0;
    send(56'h8000_0040, 2'd3);
    req_valid_i = 1'b1;
    req_paddr_i = 56'h0FFF;
    req_type_i  = 2'd0;
    repeat (3) begin
      @(negedge clk_i);
      chk_b("stall_req_ready", req_ready_o, 1'b0);
      @(posedge clk_i);
      #1;
    end
    resp_ready_i = 1'b1;
    send(56'h0FFF, 2'd0);
    send(56'h1000, 2'd0);
    send(56'h1_FFFF, 2'd3);
    drain();

    // Throughput: 8 back-to-back requests
    for (int i = 0; i < 8; i++) send(rand_addr(), 2'($urandom % 4));
    drain();

    // Random traffic with random backpressure
    bp_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (($urandom % 5) == 0) begin
        @(posedge clk_i);
        #1;
      end else begin
        send(rand_addr(), 2'($urandom % 4));
      end
    end
    bp_rand = 1'b0;
    @(posedge clk_i);
    #2 resp_ready_i = 1'b1;
    drain();

    // Reset while a faulting result is stalled
    resp_ready_i = 1'b0;
    send(56'h1_0000, 2'd3);
    @(negedge clk_i);
    chk_b("stalled_valid", resp_valid_o, 1'b1);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    q.delete();
    exp_cnt = '0;
    @(negedge clk_i);
    chk_b("mid_rst_valid", resp_valid_o, 1'b0);
`ifdef CVA6_PMA_FAULT_CNT_EN
    chk_w("mid_rst_cnt", 64'(fault_cnt_o), 64'd0);
`endif
    @(posedge clk_i);
    #1;
    rst_i        = 1'b0;
    resp_ready_i = 1'b1;
    send(56'h1_0000, 2'd3);
    send(56'h8000_1000, 2'd0);
    drain();
    repeat (2) @(posedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
